cnn_frame_feeder: RTL and testbench

Ping-pong input frame buffer directly upstream of the CNN accelerator. Accepts image bytes from a bursty byte source with a valid/ready handshake and stores them in two FRAME_LEN-byte banks. Replays each complete frame to the accelerator as one unbroken valid burst. Waits for the accelerator's result pulse, or a timeout, before releasing the bank and sending the next frame.

---
 rtl/cnn_frame_feeder.sv | 171 +++++++++++++++++
 tb/tb_cnn_frame_feeder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_feeder
// Purpose  : Ping-pong byte frame buffer that replays each complete frame to
//            the CNN accelerator as one burst and waits for its result pulse.
// Revision : 1.0
// ============================================================================
module cnn_frame_feeder #(
    parameter int FRAME_LEN = 884,
    parameter int TIMEOUT   = 300000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  data_in,
    output logic        valid_in,
    input  logic        done_in,
    output logic        frame_start,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] frames_sent
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam int MW = $clog2(2 * FRAME_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);
    localparam logic [MW-1:0] BANK1_BASE = MW'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]      full_q, full_d;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            timeout_err_q, timeout_err_d;
    logic [15:0]     frames_sent_q, frames_sent_d;
    logic            valid_in_q, valid_in_d;
    logic            frame_start_q, frame_start_d;

    logic [7:0]      mem [0:2*FRAME_LEN-1];
    logic [7:0]      ram_rd_q;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [MW-1:0]   w_wr_idx;
    logic [MW-1:0]   w_rd_idx;

    assign s_ready  = rst_n & ~full_q[wr_bank_q];
    assign w_wr_en  = s_valid & s_ready;
    assign w_wr_idx = wr_bank_q ? (BANK1_BASE + MW'(wr_addr_q)) : MW'(wr_addr_q);
    assign w_rd_idx = rd_bank_q ? (BANK1_BASE + MW'(rd_addr_q)) : MW'(rd_addr_q);

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_addr_d     = wr_addr_q;
        full_d        = full_q;
        rd_bank_d     = rd_bank_q;
        rd_addr_d     = rd_addr_q;
        tmo_d         = tmo_q;
        timeout_err_d = timeout_err_q;
        frames_sent_d = frames_sent_q;
        valid_in_d    = 1'b0;
        frame_start_d = 1'b0;
        w_rd_en       = 1'b0;

        if (w_wr_en) begin
            if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d         = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        // Release is evaluated after the fill so it wins on a shared bank.
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = ST_STREAM;
                    rd_addr_d = '0;
                end
            end
            ST_STREAM: begin
                w_rd_en       = 1'b1;
                valid_in_d    = 1'b1;
                frame_start_d = (rd_addr_q == '0);
                if (rd_addr_q == LAST_ADDR) begin
                    rd_addr_d     = '0;
                    tmo_d         = '0;
                    frames_sent_d = frames_sent_q + 16'd1;
                    state_d       = ST_WAIT_DONE;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (done_in || (tmo_q == LAST_TICK)) begin
                    if (!done_in) begin
                        timeout_err_d = 1'b1;
                    end
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    tmo_d             = '0;
                    state_d           = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            full_q        <= 2'b00;
            rd_bank_q     <= 1'b0;
            rd_addr_q     <= '0;
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
            frames_sent_q <= 16'd0;
            valid_in_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            full_q        <= full_d;
            rd_bank_q     <= rd_bank_d;
            rd_addr_q     <= rd_addr_d;
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
            frames_sent_q <= frames_sent_d;
            valid_in_q    <= valid_in_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_wr_idx] <= s_data;
        end
        if (w_rd_en) begin
            ram_rd_q <= mem[w_rd_idx];
        end
    end

    assign data_in     = valid_in_q ? ram_rd_q : 8'h00;
    assign valid_in    = valid_in_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;
    assign frames_sent = frames_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_frame_feeder
// Purpose  : Scoreboard bench for cnn_frame_feeder: accepted bytes are queued
//            and compared in order against every valid_in output byte.
// Revision : 1.0
// ============================================================================
module tb_cnn_frame_feeder;

    localparam int FRAME_LEN  = 884;
    localparam int TB_TIMEOUT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        done_in = 1'b0;
    logic        frame_start;
    logic        busy;
    logic        timeout_err;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int run_len = 0;
    int starts = 0;
    logic prev_v = 1'b0;
    int exp_frames = 0;

    cnn_frame_feeder #(
        .FRAME_LEN (FRAME_LEN),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .done_in     (done_in),
        .frame_start (frame_start),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // Output monitor: byte order, burst contiguity and frame_start alignment.
    always @(negedge clk) begin
        logic [7:0] want;
        if (!rst_n) begin
            run_len = 0;
            prev_v  = 1'b0;
        end else begin
            if (valid_in || frame_start) begin
                checks++;
                if (frame_start !== (valid_in && !prev_v)) begin
                    errors++;
                    $display("FAIL frame_start_align: got %0b required %0b", frame_start, valid_in && !prev_v);
                end
                if (frame_start) starts++;
            end
            if (valid_in) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_unexpected: got %02h required none", data_in);
                end else begin
                    want = exp_q.pop_front();
                    if (data_in !== want) begin
                        errors++;
                        $display("FAIL data_byte %0d: got %02h required %02h", run_len, data_in, want);
                    end
                end
                run_len++;
            end else if (prev_v) begin
                checks++;
                if (run_len != FRAME_LEN) begin
                    errors++;
                    $display("FAIL burst_len: got %0d required %0d", run_len, FRAME_LEN);
                end
                run_len = 0;
            end
            prev_v = valid_in;
        end
    end

    function automatic logic [7:0] pat(input int p, input int i);
        case (p)
            0:       return 8'(i % 256);
            1:       return 8'(255 - (i % 256));
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    task automatic feed(input int n, input int duty, input int p);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            s_valid = ($urandom_range(99) < duty);
            s_data  = pat(p, idx);
            #1;
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                idx++;
            end
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL feed_accept: got %0d required %0d", idx, n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int cyc = 0;
        while (frames_sent != 16'(target) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        while (valid_in && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (frames_sent !== 16'(target) || valid_in !== 1'b0) begin
            errors++;
            $display("FAIL wait_frames: got frames=%0d valid=%0b required frames=%0d valid=0", frames_sent, valid_in, target);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, valid_in, frame_start, busy, timeout_err} !== 5'b0 || frames_sent !== 16'd0 || data_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got rdy=%0b v=%0b fs=%0b busy=%0b to=%0b cnt=%0d d=%02h required all 0",
                     s_ready, valid_in, frame_start, busy, timeout_err, frames_sent, data_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%0b busy=%0b required rdy=1 busy=0", s_ready, busy);
        end
    endtask

    task automatic test_basic();
        int s0 = starts;
        logic [2:0] seen;
        feed(FRAME_LEN, 100, 0);
        @(negedge clk); seen[0] = valid_in;
        @(negedge clk); seen[1] = valid_in;
        @(negedge clk); seen[2] = valid_in;
        checks++;
        if (seen !== 3'b100 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got valid seq=%03b fs=%0b required 100 fs=1", seen, frame_start);
        end
        exp_frames = 1;
        wait_frames(exp_frames);
        checks++;
        if (starts - s0 != 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_starts: got starts=%0d busy=%0b required 1 busy=1", starts - s0, busy);
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_ping_pong();
        int base = exp_frames;
        bit any_ready = 1'b0;
        logic [1:0] seen;
        feed(2 * FRAME_LEN, 100, 2);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL pp_full_ready: got %0b required 0", s_ready);
        end
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = 8'hEE;
            @(negedge clk);
            if (s_ready) any_ready = 1'b1;
        end
        s_valid = 1'b0;
        checks++;
        if (any_ready) begin
            errors++;
            $display("FAIL pp_backpressure: got ready seen=1 required 0");
        end
        wait_frames(base + 1);
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || valid_in !== 1'b0) begin
            errors++;
            $display("FAIL pp_release_ready: got rdy=%0b v=%0b required rdy=1 v=0", s_ready, valid_in);
        end
        @(negedge clk); seen[0] = valid_in;
        @(negedge clk); seen[1] = valid_in;
        checks++;
        if (seen !== 2'b10) begin
            errors++;
            $display("FAIL pp_second_latency: got %02b required 10", seen);
        end
        feed(FRAME_LEN, 100, 0);
        wait_frames(base + 2);
        pulse_done();
        wait_frames(base + 3);
        pulse_done();
        exp_frames = base + 3;
    endtask

    task automatic test_bursty();
        feed(FRAME_LEN, 30, 1);
        exp_frames++;
        wait_frames(exp_frames);
        pulse_done();
    endtask

    task automatic test_spurious_done();
        int cyc = 0;
        bit dropped = 1'b0;
        pulse_done();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frames_sent !== 16'(exp_frames) || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL spur_idle: got busy=%0b cnt=%0d rdy=%0b required 0 %0d 1", busy, frames_sent, s_ready, exp_frames);
        end
        feed(FRAME_LEN, 100, 2);
        while (run_len < 100 && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        exp_frames++;
        wait_frames(exp_frames);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped || frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL spur_stream: got dropped=%0b cnt=%0d required 0 %0d", dropped, frames_sent, exp_frames);
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_release: got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        feed(FRAME_LEN, 100, 0);
        exp_frames++;
        while (frames_sent != 16'(exp_frames) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (TB_TIMEOUT - 1) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err=%0b busy=%0b required 0 1", timeout_err, busy);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: got err=%0b busy=%0b rdy=%0b required 1 0 1", timeout_err, busy, s_ready);
        end
        feed(FRAME_LEN, 100, 1);
        exp_frames++;
        wait_frames(exp_frames);
        pulse_done();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%0b busy=%0b required 1 0", timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int s0;
        feed(FRAME_LEN, 100, 2);
        while (run_len < 400 && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_in !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd0 || s_ready !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b busy=%0b cnt=%0d rdy=%0b err=%0b required all 0",
                     valid_in, busy, frames_sent, s_ready, timeout_err);
        end
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        s0 = starts;
        feed(FRAME_LEN, 100, 1);
        wait_frames(1);
        checks++;
        if (starts - s0 != 1) begin
            errors++;
            $display("FAIL reset_restart: got starts=%0d required 1", starts - s0);
        end
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ping_pong();
        test_bursty();
        test_spurious_done();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
